// File: rtl/hja_led_sched_if.sv
// rtl/hja_led_sched_if.sv - page mux, pipeline hold and LED signals of hja_led_sched
// HJA_LED_SCHED_TRIG_CNT_EN adds the trig_drop counter output.
interface hja_led_sched_if;
    logic [7:0]  sw_page;
    logic        scan_en;
    logic        arm;
    logic        trig;
    logic        clr;
    logic        hold_ack;
    logic [15:0] debug_word;
    logic [7:0]  page_sel;
    logic [15:0] led_out;
    logic        hold_req;
    logic [2:0]  state_out;
    logic        cap_err;
`ifdef HJA_LED_SCHED_TRIG_CNT_EN
    logic [7:0]  trig_drop;
`endif

    modport master (
        output sw_page, scan_en, arm, trig, clr, hold_ack, debug_word,
`ifdef HJA_LED_SCHED_TRIG_CNT_EN
        input  trig_drop,
`endif
        input  page_sel, led_out, hold_req, state_out, cap_err
    );

    modport slave (
        input  sw_page, scan_en, arm, trig, clr, hold_ack, debug_word,
`ifdef HJA_LED_SCHED_TRIG_CNT_EN
        output trig_drop,
`endif
        output page_sel, led_out, hold_req, state_out, cap_err
    );
endinterface

// File: rtl/hja_led_sched.sv
// rtl/hja_led_sched.sv - debug LED page scheduler: live follow, dwell scan, halted snapshot capture
// HJA_LED_SCHED_TRIG_CNT_EN adds a saturating count of triggers dropped while busy.
module hja_led_sched #(
    parameter logic [7:0]         PAGE_FIRST  = 8'h00,
    parameter logic [7:0]         PAGE_LAST   = 8'h49,
    parameter int                 DWELL_W     = 24,
    parameter logic [DWELL_W-1:0] DWELL       = 24'd5000000,
    parameter int                 ACK_TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    hja_led_sched_if.slave bus
);
    localparam int N     = int'(PAGE_LAST) - int'(PAGE_FIRST) + 1;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_LIVE     = 3'd0,
        S_SCAN     = 3'd1,
        S_HALT_REQ = 3'd2,
        S_CAPTURE  = 3'd3,
        S_REVIEW   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         page_sel_q, page_sel_d;
    logic [15:0]        led_q, led_d;
    logic               hold_req_q, hold_req_d;
    logic               cap_err_q, cap_err_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [15:0]        cap_buf_q [N];

    logic        trig_fire, tmo_done, dwell_done, cap_last, rev_hit;
    logic [7:0]  rev_off, scan_next;
    logic [15:0] rev_word;

    assign trig_fire  = bus.trig & bus.arm;
    assign tmo_done   = (tmo_q == TMO_W'(ACK_TIMEOUT - 1));
    assign dwell_done = (dwell_q == DWELL - DWELL_W'(1));
    assign cap_last   = (idx_q == IDX_W'(N - 1));
    assign scan_next  = (page_sel_q == PAGE_LAST) ? PAGE_FIRST : page_sel_q + 8'd1;

    // Pages below PAGE_FIRST wrap to a large offset, so one compare covers both range ends.
    assign rev_off  = bus.sw_page - PAGE_FIRST;
    assign rev_hit  = (rev_off <= (PAGE_LAST - PAGE_FIRST));
    assign rev_word = rev_hit ? cap_buf_q[rev_off[IDX_W-1:0]] : 16'h0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LIVE;
            page_sel_q <= 8'h00;
            led_q      <= 16'h0000;
            hold_req_q <= 1'b0;
            cap_err_q  <= 1'b0;
            dwell_q    <= '0;
            idx_q      <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            page_sel_q <= page_sel_d;
            led_q      <= led_d;
            hold_req_q <= hold_req_d;
            cap_err_q  <= cap_err_d;
            dwell_q    <= dwell_d;
            idx_q      <= idx_d;
            tmo_q      <= tmo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_CAPTURE) begin
            cap_buf_q[idx_q] <= bus.debug_word;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LIVE: begin
                if (trig_fire)        state_d = S_HALT_REQ;
                else if (bus.scan_en) state_d = S_SCAN;
            end
            S_SCAN: begin
                if (trig_fire)         state_d = S_HALT_REQ;
                else if (!bus.scan_en) state_d = S_LIVE;
            end
            S_HALT_REQ: begin
                if (bus.hold_ack)  state_d = S_CAPTURE;
                else if (tmo_done) state_d = bus.scan_en ? S_SCAN : S_LIVE;
            end
            S_CAPTURE: begin
                if (cap_last) state_d = S_REVIEW;
            end
            S_REVIEW: begin
                if (bus.clr) state_d = bus.scan_en ? S_SCAN : S_LIVE;
            end
            default: state_d = S_LIVE;
        endcase
    end

    always_comb begin
        page_sel_d = page_sel_q;
        led_d      = led_q;
        hold_req_d = hold_req_q;
        cap_err_d  = bus.clr ? 1'b0 : cap_err_q;
        dwell_d    = dwell_q;
        idx_d      = idx_q;
        tmo_d      = tmo_q;
        case (state_q)
            S_LIVE: begin
                page_sel_d = bus.sw_page;
                led_d      = bus.debug_word;
                if (trig_fire) begin
                    hold_req_d = 1'b1;
                    tmo_d      = '0;
                end else if (bus.scan_en) begin
                    page_sel_d = PAGE_FIRST;
                    dwell_d    = '0;
                end
            end
            S_SCAN: begin
                led_d = bus.debug_word;
                if (trig_fire) begin
                    hold_req_d = 1'b1;
                    tmo_d      = '0;
                end else if (bus.scan_en) begin
                    if (dwell_done) begin
                        dwell_d    = '0;
                        page_sel_d = scan_next;
                    end else begin
                        dwell_d = dwell_q + DWELL_W'(1);
                    end
                end
            end
            S_HALT_REQ: begin
                if (bus.hold_ack) begin
                    page_sel_d = PAGE_FIRST;
                    idx_d      = '0;
                    cap_err_d  = 1'b0;
                end else if (tmo_done) begin
                    hold_req_d = 1'b0;
                    cap_err_d  = 1'b1;
                    if (bus.scan_en) begin
                        page_sel_d = PAGE_FIRST;
                        dwell_d    = '0;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_CAPTURE: begin
                if (cap_last) begin
                    hold_req_d = 1'b0;
                end else begin
                    idx_d      = idx_q + IDX_W'(1);
                    page_sel_d = page_sel_q + 8'd1;
                end
            end
            S_REVIEW: begin
                page_sel_d = bus.sw_page;
                led_d      = rev_word;
                if (bus.clr && bus.scan_en) begin
                    page_sel_d = PAGE_FIRST;
                    dwell_d    = '0;
                end
            end
            default: ;
        endcase
    end

`ifdef HJA_LED_SCHED_TRIG_CNT_EN
    logic [7:0] drop_q, drop_d;
    logic       busy;

    assign busy = (state_q == S_HALT_REQ) || (state_q == S_CAPTURE) || (state_q == S_REVIEW);

    always_comb begin
        drop_d = drop_q;
        if ((state_q == S_REVIEW) && bus.clr) begin
            drop_d = 8'h00;
        end else if (trig_fire && busy && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) drop_q <= 8'h00;
        else     drop_q <= drop_d;
    end

    assign bus.trig_drop = drop_q;
`else
    // Triggers arriving while busy are discarded without trace.
`endif

    assign bus.page_sel  = page_sel_q;
    assign bus.led_out   = led_q;
    assign bus.hold_req  = hold_req_q;
    assign bus.state_out = state_q;
    assign bus.cap_err   = cap_err_q;
endmodule

// File: tb/tb_hja_led_sched.sv
// tb/tb_hja_led_sched.sv - scoreboard bench for hja_led_sched
module tb_hja_led_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  tag;
    int          vec_cnt = 0;
    int          miss_cnt = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    hja_led_sched_if dif ();
    hja_led_sched_if sif ();

    assign dif.debug_word = {tag, dif.page_sel};
    assign sif.debug_word = {8'h5A, sif.page_sel};

    hja_led_sched #(.PAGE_FIRST(8'h00), .PAGE_LAST(8'h49), .DWELL_W(24), .DWELL(24'd4), .ACK_TIMEOUT(16))
        u_dut (.clk(clk), .rst(rst), .bus(dif.slave));
    hja_led_sched #(.PAGE_FIRST(8'h47), .PAGE_LAST(8'h49), .DWELL_W(24), .DWELL(24'd4), .ACK_TIMEOUT(16))
        u_scan (.clk(clk), .rst(rst), .bus(sif.slave));

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; tag = 8'hA5;
        dif.sw_page = 8'h00; dif.scan_en = 0; dif.arm = 0; dif.trig = 0; dif.clr = 0; dif.hold_ack = 0;
        sif.sw_page = 8'h00; sif.scan_en = 0; sif.arm = 0; sif.trig = 0; sif.clr = 0; sif.hold_ack = 0;
        tick(3);
        vec_cnt++; if (dif.state_out !== 3'd0) begin miss_cnt++; $display("FAIL reset_state got %0d want 0", dif.state_out); end
        vec_cnt++; if (dif.page_sel !== 8'h00) begin miss_cnt++; $display("FAIL reset_page got %h want 00", dif.page_sel); end
        vec_cnt++; if (dif.led_out !== 16'h0000) begin miss_cnt++; $display("FAIL reset_led got %h want 0000", dif.led_out); end
        vec_cnt++; if (dif.hold_req !== 1'b0) begin miss_cnt++; $display("FAIL reset_hold got %b want 0", dif.hold_req); end
        vec_cnt++; if (dif.cap_err !== 1'b0) begin miss_cnt++; $display("FAIL reset_cap_err got %b want 0", dif.cap_err); end
        vec_cnt++; if (sif.state_out !== 3'd0) begin miss_cnt++; $display("FAIL reset_scan_state got %0d want 0", sif.state_out); end
`ifdef HJA_LED_SCHED_TRIG_CNT_EN
        vec_cnt++; if (dif.trig_drop !== 8'h00) begin miss_cnt++; $display("FAIL reset_trig_drop got %h want 00", dif.trig_drop); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_live;
        logic [7:0]  pg [4] = '{8'h0F, 8'h21, 8'h49, 8'h80};
        logic [15:0] e;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                dif.sw_page = pg[i];
                exp_q.push_back({8'hA5, pg[i]});
            end
            tick(1);
            if (i < 4) begin
                vec_cnt++; if (dif.page_sel !== pg[i]) begin miss_cnt++; $display("FAIL live_page got %h want %h", dif.page_sel, pg[i]); end
            end
            if (i >= 1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vec_cnt++; if (dif.led_out !== e) begin miss_cnt++; $display("FAIL live_led got %h want %h", dif.led_out, e); end
            end
        end
        vec_cnt++; if (dif.state_out !== 3'd0) begin miss_cnt++; $display("FAIL live_state got %0d want 0", dif.state_out); end
    endtask

    task automatic test_scan_wrap;
        logic [15:0] e;
        logic [7:0]  prev = 8'h00;
        exp_q.delete();
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 4; k++) exp_q.push_back({8'h00, 8'h47 + 8'(p)});
        exp_q.push_back(16'h0047);
        exp_q.push_back(16'h0047);
        sif.scan_en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            e = exp_q.pop_front();
            if (i == 0) begin
                vec_cnt++; if (sif.state_out !== 3'd1) begin miss_cnt++; $display("FAIL scan_state got %0d want 1", sif.state_out); end
            end
            vec_cnt++; if (sif.page_sel !== e[7:0]) begin miss_cnt++; $display("FAIL scan_page[%0d] got %h want %h", i, sif.page_sel, e[7:0]); end
            vec_cnt++; if (sif.led_out !== {8'h5A, prev}) begin miss_cnt++; $display("FAIL scan_led[%0d] got %h want %h", i, sif.led_out, {8'h5A, prev}); end
            prev = e[7:0];
        end
        sif.scan_en = 1'b0;
        tick(1);
        vec_cnt++; if (sif.state_out !== 3'd0) begin miss_cnt++; $display("FAIL scan_exit got %0d want 0", sif.state_out); end
    endtask

    task automatic test_capture;
        int halt_n = 0;
        int cap_n  = 0;
        bit done   = 0;
        logic [7:0]  rp [6] = '{8'h21, 8'h80, 8'h00, 8'h49, 8'h4A, 8'h10};
        logic [15:0] rw [6] = '{16'hA521, 16'h0000, 16'hA500, 16'hA549, 16'h0000, 16'hA510};
        logic [15:0] e;
        dif.scan_en = 0; dif.arm = 1; dif.trig = 1;
        tick(1);
        dif.trig = 0;
        for (int c = 1; c <= 200 && !done; c++) begin
            if (dif.hold_req === 1'b1 && dif.state_out === 3'd2) halt_n++;
            if (dif.hold_req === 1'b1 && dif.state_out === 3'd3) cap_n++;
            if (c == 4)  dif.hold_ack = 1'b1;
            if (c == 30) dif.hold_ack = 1'b0;
            if (dif.state_out === 3'd4) done = 1; else tick(1);
        end
        vec_cnt++; if (!done) begin miss_cnt++; $display("FAIL capture_review_wait got state %0d want 4", dif.state_out); end
        vec_cnt++; if (halt_n != 4) begin miss_cnt++; $display("FAIL capture_halt_cycles got %0d want 4", halt_n); end
        vec_cnt++; if (cap_n != 74) begin miss_cnt++; $display("FAIL capture_cycles got %0d want 74", cap_n); end
        vec_cnt++; if (dif.hold_req !== 1'b0) begin miss_cnt++; $display("FAIL review_hold got %b want 0", dif.hold_req); end
        vec_cnt++; if (dif.cap_err !== 1'b0) begin miss_cnt++; $display("FAIL capture_cap_err got %b want 0", dif.cap_err); end
        tag = 8'hC3;
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            dif.sw_page = rp[i];
            exp_q.push_back(rw[i]);
            tick(1);
            e = exp_q.pop_front();
            vec_cnt++; if (dif.led_out !== e) begin miss_cnt++; $display("FAIL review_led[%h] got %h want %h", rp[i], dif.led_out, e); end
            vec_cnt++; if (dif.page_sel !== rp[i]) begin miss_cnt++; $display("FAIL review_page got %h want %h", dif.page_sel, rp[i]); end
        end
    endtask

    task automatic test_timeout;
        int hr_n = 0;
        dif.scan_en = 1; dif.clr = 1;
        tick(1);
        dif.clr = 0;
        vec_cnt++; if (dif.state_out !== 3'd1) begin miss_cnt++; $display("FAIL review_clr_state got %0d want 1", dif.state_out); end
        vec_cnt++; if (dif.page_sel !== 8'h00) begin miss_cnt++; $display("FAIL review_clr_page got %h want 00", dif.page_sel); end
        dif.trig = 1;
        tick(1);
        dif.trig = 0;
        for (int c = 0; c < 40 && dif.state_out === 3'd2; c++) begin
            if (dif.hold_req === 1'b1) hr_n++;
            tick(1);
        end
        vec_cnt++; if (hr_n != 16) begin miss_cnt++; $display("FAIL timeout_hold_cycles got %0d want 16", hr_n); end
        vec_cnt++; if (dif.state_out !== 3'd1) begin miss_cnt++; $display("FAIL timeout_state got %0d want 1", dif.state_out); end
        vec_cnt++; if (dif.hold_req !== 1'b0) begin miss_cnt++; $display("FAIL timeout_hold got %b want 0", dif.hold_req); end
        vec_cnt++; if (dif.cap_err !== 1'b1) begin miss_cnt++; $display("FAIL timeout_cap_err got %b want 1", dif.cap_err); end
        vec_cnt++; if (dif.page_sel !== 8'h00) begin miss_cnt++; $display("FAIL timeout_scan_page got %h want 00", dif.page_sel); end
        dif.clr = 1;
        tick(1);
        dif.clr = 0;
        vec_cnt++; if (dif.cap_err !== 1'b0) begin miss_cnt++; $display("FAIL clr_cap_err got %b want 0", dif.cap_err); end
        vec_cnt++; if (dif.state_out !== 3'd1) begin miss_cnt++; $display("FAIL clr_state got %0d want 1", dif.state_out); end
    endtask

    task automatic test_collisions;
        dif.trig = 1; dif.scan_en = 0;
        tick(1);
        dif.trig = 0;
        vec_cnt++; if (dif.state_out !== 3'd2) begin miss_cnt++; $display("FAIL coll_trig_scan got %0d want 2", dif.state_out); end
        for (int c = 0; c < 40 && dif.state_out === 3'd2; c++) tick(1);
        vec_cnt++; if (dif.state_out !== 3'd0) begin miss_cnt++; $display("FAIL coll_timeout_live got %0d want 0", dif.state_out); end
        vec_cnt++; if (dif.cap_err !== 1'b1) begin miss_cnt++; $display("FAIL coll_cap_err_set got %b want 1", dif.cap_err); end
        dif.trig = 1;
        tick(1);
        dif.trig = 0;
        tick(15);
        vec_cnt++; if (dif.state_out !== 3'd2) begin miss_cnt++; $display("FAIL coll_pre_ack_state got %0d want 2", dif.state_out); end
        dif.hold_ack = 1;
        tick(1);
        dif.hold_ack = 0;
        vec_cnt++; if (dif.state_out !== 3'd3) begin miss_cnt++; $display("FAIL coll_ack_wins got %0d want 3", dif.state_out); end
        vec_cnt++; if (dif.cap_err !== 1'b0) begin miss_cnt++; $display("FAIL coll_ack_cap_err got %b want 0", dif.cap_err); end
        for (int c = 0; c < 100 && dif.state_out !== 3'd4; c++) tick(1);
        for (int k = 0; k < 3; k++) begin
            dif.trig = 1; tick(1);
            dif.trig = 0; tick(1);
        end
        vec_cnt++; if (dif.state_out !== 3'd4) begin miss_cnt++; $display("FAIL review_trig_ignored got %0d want 4", dif.state_out); end
        vec_cnt++; if (dif.hold_req !== 1'b0) begin miss_cnt++; $display("FAIL review_trig_hold got %b want 0", dif.hold_req); end
`ifdef HJA_LED_SCHED_TRIG_CNT_EN
        vec_cnt++; if (dif.trig_drop !== 8'd3) begin miss_cnt++; $display("FAIL trig_drop got %0d want 3", dif.trig_drop); end
`endif
        dif.clr = 1;
        tick(1);
        dif.clr = 0;
        vec_cnt++; if (dif.state_out !== 3'd0) begin miss_cnt++; $display("FAIL review_clr_live got %0d want 0", dif.state_out); end
`ifdef HJA_LED_SCHED_TRIG_CNT_EN
        vec_cnt++; if (dif.trig_drop !== 8'd0) begin miss_cnt++; $display("FAIL trig_drop_clr got %0d want 0", dif.trig_drop); end
`endif
    endtask

    task automatic test_reset_mid_capture;
        bit hit = 0;
        dif.sw_page = 8'h33; dif.hold_ack = 1; dif.trig = 1;
        tick(1);
        dif.trig = 0;
        for (int c = 0; c < 40 && !hit; c++) begin
            if (dif.state_out === 3'd3 && dif.page_sel === 8'd10) hit = 1; else tick(1);
        end
        vec_cnt++; if (!hit) begin miss_cnt++; $display("FAIL midcap_reach got state %0d page %h want 3/0a", dif.state_out, dif.page_sel); end
        rst = 1;
        tick(1);
        rst = 0; dif.hold_ack = 0;
        vec_cnt++; if (dif.state_out !== 3'd0) begin miss_cnt++; $display("FAIL midcap_state got %0d want 0", dif.state_out); end
        vec_cnt++; if (dif.hold_req !== 1'b0) begin miss_cnt++; $display("FAIL midcap_hold got %b want 0", dif.hold_req); end
        vec_cnt++; if (dif.page_sel !== 8'h00) begin miss_cnt++; $display("FAIL midcap_page got %h want 00", dif.page_sel); end
        vec_cnt++; if (dif.led_out !== 16'h0000) begin miss_cnt++; $display("FAIL midcap_led got %h want 0000", dif.led_out); end
    endtask

    initial begin
        test_reset();
        test_live();
        test_scan_wrap();
        test_capture();
        test_timeout();
        test_collisions();
        test_reset_mid_capture();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
